// File: rtl/mult_seq_pkg.sv
// Shared types, constants and the carry-save helper for the nibble-serial multiplier.
//   IDLE/MUL/DONE : sequencer state encodings
//   NIB_W         : nibble width fed to the 4x4 multiplier
//   PP_W          : width of one nibble-pair partial product
//   csa3()        : 3:2 carry-save compressor, returns {carry, sum}
package mult_seq_pkg;

  typedef logic [1:0] state_t;

  localparam state_t IDLE = 2'd0;
  localparam state_t MUL  = 2'd1;
  localparam state_t DONE = 2'd2;

  localparam int NIB_W = 4;
  localparam int PP_W  = 8;

  // Carry vector is pre-shifted into its final weight; the top carry bit can be
  // dropped because a 4x4 product never reaches 2^PP_W.
  function automatic logic [2*PP_W-1:0] csa3(input logic [PP_W-1:0] x,
                                             input logic [PP_W-1:0] y,
                                             input logic [PP_W-1:0] z);
    logic [PP_W-1:0] sum_v;
    logic [PP_W-1:0] carry_v;
    sum_v   = x ^ y ^ z;
    carry_v = ((x & y) | (x & z) | (y & z)) << 1;
    return {carry_v, sum_v};
  endfunction

endpackage

// File: rtl/csa_multiplier.sv
// Combinational 4x4 unsigned carry-save array multiplier.
//   a : 4-bit multiplicand
//   b : 4-bit multiplier
//   p : 8-bit product a*b
module csa_multiplier
  import mult_seq_pkg::*;
(
  input  logic [NIB_W-1:0] a,
  input  logic [NIB_W-1:0] b,
  output logic [PP_W-1:0]  p
);

  logic [PP_W-1:0] pp0_s, pp1_s, pp2_s, pp3_s;
  logic [PP_W-1:0] s1_s, c1_s, s2_s, c2_s;

  // Partial-product rows, two carry-save levels, one final carry-propagate add.
  always_comb begin
    pp0_s = {4'b0000, a & {4{b[0]}}};
    pp1_s = {3'b000,  a & {4{b[1]}}, 1'b0};
    pp2_s = {2'b00,   a & {4{b[2]}}, 2'b00};
    pp3_s = {1'b0,    a & {4{b[3]}}, 3'b000};
    {c1_s, s1_s} = csa3(pp0_s, pp1_s, pp2_s);
    {c2_s, s2_s} = csa3(s1_s, c1_s, pp3_s);
    p = s2_s + c2_s;
  end

endmodule

// File: rtl/mult_seq_ctrl.sv
// Nibble-serial WIDTH x WIDTH unsigned multiplier sequencer. One nibble-pair
// product per cycle is shift-accumulated into a 2*WIDTH accumulator; the result
// is offered on a valid/ready port and held stable under backpressure.
//   clk, rst            : clock, synchronous active-high reset
//   in_valid/in_ready   : operand handshake for a, b
//   a, b                : unsigned operands (WIDTH bits)
//   out_valid/out_ready : result handshake for p
//   p                   : product a*b (2*WIDTH bits)
//   busy                : high while the multiply steps run
module mult_seq_ctrl
  import mult_seq_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] p,
  output logic               busy
);

  localparam int NNIB   = WIDTH / NIB_W;
  localparam int NSTEP  = NNIB * NNIB;
  localparam int STEP_W = (NSTEP > 1) ? $clog2(NSTEP) : 1;
  localparam int IDX_W  = (NNIB > 1) ? $clog2(NNIB) : 1;
  localparam int PW     = 2 * WIDTH;
  localparam int SH_W   = IDX_W + 3;

  localparam logic [STEP_W-1:0] LAST_STEP = STEP_W'(NSTEP - 1);
  localparam logic [STEP_W-1:0] NNIB_C    = STEP_W'(NNIB);

  state_t             state_r, state_nxt_s;
  logic [STEP_W-1:0]  step_r;
  logic [WIDTH-1:0]   a_r, b_r;
  logic [PW-1:0]      acc_r, acc_nxt_s;
  logic [PW-1:0]      p_r;
  logic               in_ready_r, out_valid_r, busy_r;
  logic               in_ready_nxt_s, out_valid_nxt_s, busy_nxt_s;
  logic [IDX_W-1:0]   i_s, j_s;
  logic [NIB_W-1:0]   a_nib_s, b_nib_s;
  logic [PP_W-1:0]    pp_s;
  logic [SH_W-1:0]    shamt_s;

  assign in_ready  = in_ready_r;
  assign out_valid = out_valid_r;
  assign busy      = busy_r;
  assign p         = p_r;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state logic; a DONE-state output handshake always returns to IDLE
  // first, so a simultaneous in_valid is taken on the following cycle.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE: begin
        if (in_valid) state_nxt_s = MUL;
        else          state_nxt_s = IDLE;
      end
      MUL: begin
        if (step_r == LAST_STEP) state_nxt_s = DONE;
        else                     state_nxt_s = MUL;
      end
      DONE: begin
        if (out_ready) state_nxt_s = IDLE;
        else           state_nxt_s = DONE;
      end
      default: state_nxt_s = IDLE;
    endcase
  end

  // Output decode from the next state so the handshake flags are registered.
  always_comb begin
    in_ready_nxt_s  = 1'b0;
    busy_nxt_s      = 1'b0;
    out_valid_nxt_s = 1'b0;
    case (state_nxt_s)
      IDLE:    in_ready_nxt_s  = 1'b1;
      MUL:     busy_nxt_s      = 1'b1;
      DONE:    out_valid_nxt_s = 1'b1;
      default: in_ready_nxt_s  = 1'b0;
    endcase
  end

  // Output flag registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      in_ready_r  <= 1'b1;
      busy_r      <= 1'b0;
      out_valid_r <= 1'b0;
    end else begin
      in_ready_r  <= in_ready_nxt_s;
      busy_r      <= busy_nxt_s;
      out_valid_r <= out_valid_nxt_s;
    end
  end

  // Nibble select, 4x4 multiply and shift-accumulate for the current step.
  always_comb begin
    i_s       = IDX_W'(step_r / NNIB_C);
    j_s       = IDX_W'(step_r % NNIB_C);
    a_nib_s   = a_r[{i_s, 2'b00} +: NIB_W];
    b_nib_s   = b_r[{j_s, 2'b00} +: NIB_W];
    shamt_s   = {({1'b0, i_s} + {1'b0, j_s}), 2'b00};
    acc_nxt_s = acc_r + (PW'(pp_s) << shamt_s);
  end

  csa_multiplier u_csa (
    .a (a_nib_s),
    .b (b_nib_s),
    .p (pp_s)
  );

  // Operand capture, step counter, accumulator and result register.
  always_ff @(posedge clk) begin
    if (rst) begin
      a_r    <= '0;
      b_r    <= '0;
      acc_r  <= '0;
      step_r <= '0;
      p_r    <= '0;
    end else begin
      case (state_r)
        IDLE: begin
          if (in_valid) begin
            a_r    <= a;
            b_r    <= b;
            acc_r  <= '0;
            step_r <= '0;
          end
        end
        MUL: begin
          acc_r <= acc_nxt_s;
          // Counter saturates at the last step; only a new accept clears it.
          if (step_r != LAST_STEP) begin
            step_r <= step_r + 1'b1;
          end else begin
            p_r <= acc_nxt_s;
          end
        end
        DONE:    p_r <= p_r;
        default: p_r <= p_r;
      endcase
    end
  end

endmodule

// File: tb/tb_mult_seq_ctrl.sv
module tb_mult_seq_ctrl;

  localparam int NSTEP8  = 4;
  localparam int NSTEP16 = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        in_valid, in_ready, out_valid, out_ready, busy;
  logic [7:0]  a, b;
  logic [15:0] p;

  logic        in_valid16, in_ready16, out_valid16, out_ready16, busy16;
  logic [15:0] a16, b16;
  logic [31:0] p16;

  mult_seq_ctrl #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready),
    .p(p), .busy(busy)
  );

  mult_seq_ctrl #(.WIDTH(16)) dut16 (
    .clk(clk), .rst(rst), .in_valid(in_valid16), .in_ready(in_ready16),
    .a(a16), .b(b16), .out_valid(out_valid16), .out_ready(out_ready16),
    .p(p16), .busy(busy16)
  );

  typedef struct {
    logic [7:0]  a;
    logic [7:0]  b;
    logic [15:0] p;
    int          bp;
    bit          toggle;
  } vec_t;

  vec_t        vecs[8];
  logic [15:0] exp_q[$];
  logic [31:0] exp16_q[$];
  int          checks = 0;
  int          errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic wait_out8(output int lat, output int busy_cnt, input bit toggle);
    lat = 0;
    busy_cnt = 0;
    while (!out_valid && lat < 64) begin
      if (busy) busy_cnt++;
      if (toggle) begin
        in_valid = ~in_valid;
        a = 8'($urandom);
        b = 8'($urandom);
      end
      @(negedge clk);
      lat++;
    end
    in_valid = 1'b0;
  endtask

  task automatic run8(input logic [7:0] va, input logic [7:0] vb, input logic [15:0] vp,
                      input int bp, input bit toggle);
    int lat, busy_cnt;
    logic [15:0] e;
    @(negedge clk);
    in_valid = 1'b1; a = va; b = vb;
    check("in_ready_idle", in_ready, 1);
    exp_q.push_back(vp);
    @(negedge clk);
    in_valid = 1'b0; a = ~va; b = ~vb;
    check("in_ready_mul", in_ready, 0);
    wait_out8(lat, busy_cnt, toggle);
    check("out_valid", out_valid, 1);
    check("latency", lat, NSTEP8);
    check("busy_cycles", busy_cnt, NSTEP8);
    check("busy_done", busy, 0);
    e = exp_q.pop_front();
    check("p", p, e);
    repeat (bp) begin
      @(negedge clk);
      check("p_hold", p, e);
      check("out_valid_hold", out_valid, 1);
      check("in_ready_hold", in_ready, 0);
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check("out_valid_clr", out_valid, 0);
    check("in_ready_back", in_ready, 1);
  endtask

  task automatic run16(input logic [15:0] va, input logic [15:0] vb);
    int n, lat;
    n = 0;
    while (!in_ready16 && n < 64) begin
      @(negedge clk);
      n++;
    end
    in_valid16 = 1'b1; a16 = va; b16 = vb;
    exp16_q.push_back({16'h0000, va} * {16'h0000, vb});
    @(negedge clk);
    in_valid16 = 1'b0;
    lat = 0;
    while (!out_valid16 && lat < 200) begin
      @(negedge clk);
      lat++;
    end
    check("latency16", lat, NSTEP16);
    check("p16", p16, exp16_q.pop_front());
    out_ready16 = 1'b1;
    @(negedge clk);
    out_ready16 = 1'b0;
  endtask

  initial begin
    int lat, busy_cnt;
    logic [7:0] ra, rb;

    vecs[0] = '{a: 8'h12, b: 8'h34, p: 16'h03A8, bp: 10, toggle: 1'b0};
    vecs[1] = '{a: 8'hFF, b: 8'hFF, p: 16'hFE01, bp: 0,  toggle: 1'b0};
    vecs[2] = '{a: 8'h00, b: 8'hAB, p: 16'h0000, bp: 1,  toggle: 1'b0};
    vecs[3] = '{a: 8'h12, b: 8'h34, p: 16'h03A8, bp: 0,  toggle: 1'b1};
    vecs[4] = '{a: 8'hA5, b: 8'h5A, p: 16'h3A02, bp: 2,  toggle: 1'b0};
    vecs[5] = '{a: 8'h80, b: 8'h02, p: 16'h0100, bp: 0,  toggle: 1'b1};
    vecs[6] = '{a: 8'h01, b: 8'hFF, p: 16'h00FF, bp: 3,  toggle: 1'b0};
    vecs[7] = '{a: 8'hFF, b: 8'hFF, p: 16'hFE01, bp: 0,  toggle: 1'b0};

    rst = 1'b1;
    in_valid = 1'b0; out_ready = 1'b0; a = 8'h00; b = 8'h00;
    in_valid16 = 1'b0; out_ready16 = 1'b0; a16 = 16'h0000; b16 = 16'h0000;
    repeat (2) @(negedge clk);
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_p", p, 0);
    check("rst_in_ready16", in_ready16, 1);
    check("rst_p16", p16, 0);
    rst = 1'b0;

    // out_ready while idle must not disturb anything
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check("idle_out_ready", out_valid, 0);

    for (int i = 0; i < 8; i++) begin
      run8(vecs[i].a, vecs[i].b, vecs[i].p, vecs[i].bp, vecs[i].toggle);
    end

    // Reset during MUL step 2 discards the pending product.
    @(negedge clk);
    in_valid = 1'b1; a = 8'h55; b = 8'h66;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("abort_in_ready", in_ready, 1);
    check("abort_out_valid", out_valid, 0);
    check("abort_busy", busy, 0);
    check("abort_p", p, 0);
    repeat (6) begin
      @(negedge clk);
      check("abort_no_valid", out_valid, 0);
    end
    run8(8'h0F, 8'h0F, 16'h00E1, 0, 1'b0);

    // Output handshake and new in_valid together in DONE.
    @(negedge clk);
    in_valid = 1'b1; a = 8'h12; b = 8'h34;
    exp_q.push_back(16'h03A8);
    @(negedge clk);
    in_valid = 1'b0;
    wait_out8(lat, busy_cnt, 1'b0);
    check("ovl_p1", p, exp_q.pop_front());
    out_ready = 1'b1; in_valid = 1'b1; a = 8'h0F; b = 8'h0F;
    @(negedge clk);
    out_ready = 1'b0;
    check("ovl_idle_valid", out_valid, 0);
    check("ovl_idle_ready", in_ready, 1);
    check("ovl_idle_busy", busy, 0);
    exp_q.push_back(16'h00E1);
    @(negedge clk);
    in_valid = 1'b0;
    check("ovl_accept_ready", in_ready, 0);
    check("ovl_accept_busy", busy, 1);
    wait_out8(lat, busy_cnt, 1'b0);
    check("ovl_latency", lat, NSTEP8);
    check("ovl_p2", p, exp_q.pop_front());
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;

    // Random 8-bit pairs against a*b.
    for (int k = 0; k < 100; k++) begin
      ra = 8'($urandom);
      rb = 8'($urandom);
      run8(ra, rb, {8'h00, ra} * {8'h00, rb}, int'($urandom_range(0, 2)), 1'b0);
    end

    // 16-bit build: corner plus random pairs.
    run16(16'hFFFF, 16'hFFFF);
    check("p16_max", p16, 32'hFFFE0001);
    run16(16'h0000, 16'h1234);
    for (int k = 0; k < 1000; k++) begin
      run16(16'($urandom), 16'($urandom));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
